// File: rtl/counter_bounded_shift.sv
// Bounded up/down counter with shift and rotate operations.
// Wrap or saturate at programmable bounds; TC pulse and sticky OVF.
module counter_bounded_shift #(
    parameter int             N         = 8,
    parameter logic [N-1:0]   RESET_VAL = '0
) (
    input  logic         C,
    input  logic         R,
    input  logic         EN,
    input  logic [N-1:0] D,
    input  logic         L,
    input  logic         INC,
    input  logic         DEC,
    input  logic [N-1:0] STEP,
    input  logic [N-1:0] LO,
    input  logic [N-1:0] HI,
    input  logic         SAT,
    input  logic         SHL,
    input  logic         SHR,
    input  logic         ROL,
    input  logic         ROR,
    input  logic         SI,
    input  logic         CLR_OVF,
    output logic [N-1:0] Q,
    output logic         TC,
    output logic         OVF
);

    logic [N:0]   sum;
    logic [N-1:0] diff;
    logic         cnt_ok;
    logic         inc_ev;
    logic         dec_ev;
    logic         evt;
    logic [N-1:0] q_nxt;

    // Boundary detection in N+1 bits so Q+STEP cannot silently wrap
    always_comb begin
        sum    = {1'b0, Q} + {1'b0, STEP};
        diff   = Q - STEP;
        cnt_ok = (STEP != '0) && (LO <= HI);
        inc_ev = cnt_ok && (sum > {1'b0, HI});
        dec_ev = cnt_ok && ((Q < STEP) || (diff < LO));
    end

    // Select one operation by priority and flag boundary events
    always_comb begin
        q_nxt = Q;
        evt   = 1'b0;
        if (EN) begin
            if (L) begin
                q_nxt = D;
            end else if (INC || DEC) begin
                if (INC && !DEC && cnt_ok) begin
                    if (inc_ev) begin
                        evt   = 1'b1;
                        q_nxt = SAT ? HI : LO;
                    end else begin
                        q_nxt = sum[N-1:0];
                    end
                end else if (DEC && !INC && cnt_ok) begin
                    if (dec_ev) begin
                        evt   = 1'b1;
                        q_nxt = SAT ? LO : HI;
                    end else begin
                        q_nxt = diff;
                    end
                end
            end else if (SHL) begin
                q_nxt = {Q[N-2:0], SI};
            end else if (SHR) begin
                q_nxt = {SI, Q[N-1:1]};
            end else if (ROL) begin
                q_nxt = {Q[N-2:0], Q[N-1]};
            end else if (ROR) begin
                q_nxt = {Q[0], Q[N-1:1]};
            end
        end
    end

    // Register value, terminal-count pulse and sticky flag; set beats clear
    always_ff @(posedge C) begin
        if (R) begin
            Q   <= RESET_VAL;
            TC  <= 1'b0;
            OVF <= 1'b0;
        end else begin
            Q   <= q_nxt;
            TC  <= evt;
            OVF <= evt | (OVF & ~CLR_OVF);
        end
    end

endmodule

// File: tb/tb_counter_bounded_shift.sv
// Testbench for counter_bounded_shift: integer reference model,
// per-cycle compare plus directed literal checks.
module tb_counter_bounded_shift;

    localparam int N  = 4;
    localparam int RV = 5;
    localparam int M  = 1 << N;

    logic         C = 0;
    logic         R, EN, L, INC, DEC, SAT;
    logic         SHL, SHR, ROL, ROR, SI, CLR_OVF;
    logic [N-1:0] D, STEP, LO, HI;
    logic [N-1:0] Q;
    logic         TC, OVF;

    int n_chk  = 0;
    int n_fail = 0;
    int m_q, m_tc, m_ovf;
    bit chk_en = 0;

    counter_bounded_shift #(.N(N), .RESET_VAL(4'(RV))) dut (
        .C(C), .R(R), .EN(EN), .D(D), .L(L), .INC(INC), .DEC(DEC),
        .STEP(STEP), .LO(LO), .HI(HI), .SAT(SAT), .SHL(SHL), .SHR(SHR),
        .ROL(ROL), .ROR(ROR), .SI(SI), .CLR_OVF(CLR_OVF),
        .Q(Q), .TC(TC), .OVF(OVF)
    );

    always #5 C = ~C;

    // Reference model in plain integer arithmetic
    always @(posedge C) begin
        int q, st, lo, hi, ev;
        q  = m_q; st = int'(STEP); lo = int'(LO); hi = int'(HI);
        ev = 0;
        if (R) begin
            m_q = RV; m_tc = 0; m_ovf = 0;
        end else begin
            if (EN) begin
                if (L) q = int'(D);
                else if (INC && DEC) q = q;
                else if (INC) begin
                    if (st > 0 && lo <= hi) begin
                        if (q + st > hi) begin ev = 1; q = SAT ? hi : lo; end
                        else q = q + st;
                    end
                end else if (DEC) begin
                    if (st > 0 && lo <= hi) begin
                        if (q - st < lo) begin ev = 1; q = SAT ? lo : hi; end
                        else q = q - st;
                    end
                end
                else if (SHL) q = (q * 2) % M + int'(SI);
                else if (SHR) q = q / 2 + int'(SI) * (M / 2);
                else if (ROL) q = (q * 2) % M + q / (M / 2);
                else if (ROR) q = q / 2 + (q % 2) * (M / 2);
            end
            m_q   = q;
            m_tc  = ev;
            m_ovf = ev ? 1 : (CLR_OVF ? 0 : m_ovf);
        end
    end

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Compare DUT against the model every cycle once reset has applied
    always @(negedge C) begin
        if (chk_en) begin
            chk("model_q", int'(Q), m_q);
            chk("model_tc", int'(TC), m_tc);
            chk("model_ovf", int'(OVF), m_ovf);
        end
    end

    task automatic ops0();
        R = 0; L = 0; INC = 0; DEC = 0; SHL = 0; SHR = 0;
        ROL = 0; ROR = 0; SI = 0; CLR_OVF = 0;
    endtask

    task automatic tick();
        @(posedge C);
        #1;
    endtask

    task automatic ld(int v);
        ops0(); L = 1; D = 4'(v); tick(); ops0();
    endtask

    task automatic exp3(string nm, int q, int tc, int ovf);
        chk({nm, "_q"}, int'(Q), q);
        chk({nm, "_tc"}, int'(TC), tc);
        chk({nm, "_ovf"}, int'(OVF), ovf);
    endtask

    initial begin
        ops0();
        EN = 0; D = 0; STEP = 0; LO = 0; HI = 0; SAT = 0;
        m_q = 0; m_tc = 0; m_ovf = 0;
        @(negedge C);

        R = 1; L = 1; D = 9; EN = 0;
        tick();
        exp3("reset", 5, 0, 0);
        chk_en = 1;
        ops0();

        EN = 1; LO = 3; HI = 10; STEP = 3; SAT = 0;
        ld(9);
        chk("load", int'(Q), 9);
        INC = 1; tick();
        exp3("wrap_up", 3, 1, 1);
        tick();
        exp3("after_wrap", 6, 0, 1);

        ops0(); CLR_OVF = 1; tick();
        exp3("clr_ovf", 6, 0, 0);
        ld(9);
        INC = 1; CLR_OVF = 1; tick();
        exp3("set_wins", 3, 1, 1);
        ops0(); STEP = 0; INC = 1; tick();
        exp3("step0", 3, 0, 1);

        ops0(); SAT = 1; LO = 2; HI = 12; STEP = 3;
        ld(4);
        DEC = 1; tick();
        exp3("sat_dn", 2, 1, 1);
        tick();
        exp3("sat_hold", 2, 1, 1);
        ops0(); INC = 1; tick();
        exp3("sat_inc", 5, 0, 1);

        ld(9);
        SHL = 1; tick(); chk("shl", int'(Q), 2);
        ops0(); ROR = 1; tick(); chk("ror", int'(Q), 1);
        ops0(); ROL = 1; tick(); chk("rol", int'(Q), 2);
        ops0(); SHR = 1; SI = 1; tick(); chk("shr", int'(Q), 9);

        ops0(); INC = 1; DEC = 1; SHL = 1; tick();
        exp3("incdec", 9, 0, 1);
        ops0(); L = 1; INC = 1; D = 7; tick();
        exp3("ld_pri", 7, 0, 1);
        ops0(); EN = 0; INC = 1; tick();
        exp3("en0", 7, 0, 1);
        EN = 1; LO = 9; HI = 4; tick();
        exp3("lo_gt_hi", 7, 0, 1);

        ops0(); SAT = 0; LO = 0; HI = 15; STEP = 3;
        ld(1);
        DEC = 1; tick();
        exp3("dec_under", 15, 1, 1);
        ops0(); ld(14);
        INC = 1; tick();
        exp3("inc_carry", 0, 1, 1);
        ops0(); EN = 0; CLR_OVF = 1; tick();
        exp3("clr_en0", 0, 0, 0);
        EN = 1; ops0(); INC = 1; R = 1; tick();
        exp3("reset_mid", 5, 0, 0);

        for (int i = 0; i < 200; i++) begin
            ops0();
            EN = ($urandom_range(0, 7) != 0);
            R = ($urandom_range(0, 40) == 0);
            L = ($urandom_range(0, 9) == 0);
            INC = $urandom_range(0, 1); DEC = $urandom_range(0, 1);
            SHL = $urandom_range(0, 1); SHR = $urandom_range(0, 1);
            ROL = $urandom_range(0, 1); ROR = $urandom_range(0, 1);
            SI = $urandom_range(0, 1); SAT = $urandom_range(0, 1);
            CLR_OVF = ($urandom_range(0, 5) == 0);
            D = 4'($urandom); STEP = 4'($urandom_range(0, 6));
            LO = 4'($urandom_range(0, 8)); HI = 4'($urandom_range(4, 15));
            tick();
        end

        ops0();
        @(negedge C);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
